// File: rtl/pipelined_bypass_adder.sv
// Pipelined carry-bypass adder/subtractor with optional signed saturation.
// Latency: STAGES cycles from input transfer to out_valid. Throughput: one op per cycle.
// Backpressure: the whole pipe advances together only when ~out_valid | out_ready, and in_ready follows that advance.
//
// Ports:
//    clk, rst               rising-edge clock, synchronous active-high reset
//    in_valid / in_ready    operand handshake (a, b, cin, sub, sat)
//    out_valid / out_ready  result handshake (sum, cout, overflow)
//    sum                    a+b+cin or a-b-cin, clamped when sat=1 and a signed overflow occurs
//    cout                   raw carry out of the MSB, taken after B is inverted for subtract
//    overflow               signed overflow of the unsaturated result
//
// WIDTH must be a multiple of STAGES*BLOCK. Stage k adds bits [k*WIDTH/STAGES +: WIDTH/STAGES].
module pipelined_bypass_adder #(
   parameter int WIDTH  = 32,
   parameter int BLOCK  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int SEG  = WIDTH / STAGES;
   localparam int NBLK = SEG / BLOCK;

   logic advance;

   // Every stage shifts together, bubbles included. The pipe freezes only while a result waits downstream.
   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;

   for (genvar k = 0; k < STAGES; k++) begin : stg
      localparam int LOW = k * SEG;       // result bits already produced upstream
      localparam int REM = WIDTH - LOW;   // operand bits still to be added

      logic [REM-1:0]     op_a, op_b;
      logic               op_c, op_vld, op_sat;
      logic [SEG-1:0]     seg_sum;
      logic               seg_c;
      logic [LOW+SEG-1:0] lo_sum;
      logic [LOW+SEG-1:0] nx_res;
      logic               r_vld, r_c;
      logic [LOW+SEG-1:0] r_res;

      if (k == 0) begin : g_src
         // Subtraction is folded in here: invert B and the carry-in once at the entry point.
         assign op_a   = a;
         assign op_b   = sub ? ~b : b;
         assign op_c   = sub ? ~cin : cin;
         assign op_vld = in_valid;
         assign op_sat = sat;
         assign lo_sum = seg_sum;
      end else begin : g_src
         assign op_a   = stg[k-1].g_mid.r_a;
         assign op_b   = stg[k-1].g_mid.r_b;
         assign op_c   = stg[k-1].r_c;
         assign op_vld = stg[k-1].r_vld;
         assign op_sat = stg[k-1].g_mid.r_sat;
         assign lo_sum = {seg_sum, stg[k-1].r_res};
      end

      // Each block ripples internally. When every bit of the block propagates,
      // the block's carry-in is passed straight to the next block (the bypass).
      always_comb begin : seg_add
         logic c, cb, p, x;
         c       = op_c;
         cb      = 1'b0;
         p       = 1'b0;
         x       = 1'b0;
         seg_sum = '0;
         for (int j = 0; j < NBLK; j++) begin
            cb = c;
            p  = 1'b1;
            for (int i = 0; i < BLOCK; i++) begin
               x                      = op_a[j*BLOCK+i] ^ op_b[j*BLOCK+i];
               seg_sum[j*BLOCK+i]     = x ^ c;
               c                      = (op_a[j*BLOCK+i] & op_b[j*BLOCK+i]) | (x & c);
               p                      = p & x;
            end
            if (p) begin
               c = cb;
            end
         end
         seg_c = c;
      end

      if (k == STAGES - 1) begin : g_last
         logic c_msb, ovf;
         logic r_ovf;

         // The carry into the MSB is recovered from that bit's sum: s = a ^ b ^ c.
         assign c_msb  = seg_sum[SEG-1] ^ op_a[SEG-1] ^ op_b[SEG-1];
         assign ovf    = c_msb ^ seg_c;
         // On overflow, the sign of A gives the direction: a positive A can only overflow upward.
         assign nx_res = (op_sat & ovf) ?
                         (op_a[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) :
                         lo_sum;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_ovf <= 1'b0;
            end else if (advance) begin
               r_ovf <= ovf;
            end
         end
      end else begin : g_mid
         // Operand bits above this segment travel to the stages that will add them.
         logic [REM-SEG-1:0] r_a, r_b;
         logic               r_sat;

         assign nx_res = lo_sum;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_a   <= '0;
               r_b   <= '0;
               r_sat <= 1'b0;
            end else if (advance) begin
               r_a   <= op_a[REM-1:SEG];
               r_b   <= op_b[REM-1:SEG];
               r_sat <= op_sat;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            r_vld <= 1'b0;
            r_c   <= 1'b0;
            r_res <= '0;
         end else if (advance) begin
            r_vld <= op_vld;
            r_c   <= seg_c;
            r_res <= nx_res;
         end
      end
   end

   assign out_valid = stg[STAGES-1].r_vld;
   assign sum       = stg[STAGES-1].r_res;
   assign cout      = stg[STAGES-1].r_c;
   assign overflow  = stg[STAGES-1].g_last.r_ovf;

endmodule

// File: tb/tb_pipelined_bypass_adder.sv
// Bench for pipelined_bypass_adder: directed corner cases plus randomized traffic,
// checked by a queue-based scoreboard and a behavioural reference model.
module tb_pipelined_bypass_adder;

   localparam int W   = 32;
   localparam int BLK = 4;
   localparam int ST  = 2;
   localparam longint MAXS = (longint'(1) <<< (W-1)) - 1;
   localparam longint MINS = -(longint'(1) <<< (W-1));

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, cin, sub, sat, out_valid, out_ready, cout, overflow;
   logic [W-1:0] a, b, sum;
   logic         ordy_fix, ordy_rnd;
   bit           rnd_ordy = 1'b0;

   always #5 clk = ~clk;

   assign out_ready = rnd_ordy ? ordy_rnd : ordy_fix;

   pipelined_bypass_adder #(.WIDTH(W), .BLOCK(BLK), .STAGES(ST)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .sat(sat),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .overflow(overflow));

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           t;
      bit           lat;
   } exp_t;

   exp_t q[$];
   int   nvec = 0;
   int   nerr = 0;
   int   cyc  = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) ordy_rnd = ($urandom_range(0, 3) != 0);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      nvec++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o, input bit l);
      exp_t e;
      e.sum = s; e.cout = c; e.ovf = o; e.t = 0; e.lat = l;
      return e;
   endfunction

   // Reference: the unsigned (W+1)-bit sum gives the raw result and carry. The exact signed
   // value of a+b+cin or a-b-cin gives overflow and the clamp direction.
   function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic c, input logic s, input logic st);
      exp_t        e;
      logic [W:0]  wide;
      longint      t, bs;
      wide = {1'b0, av} + {1'b0, (s ? ~bv : bv)} + {{W{1'b0}}, (s ? ~c : c)};
      bs   = longint'($signed(bv));
      t    = longint'($signed(av)) + (s ? -(bs + longint'(c)) : (bs + longint'(c)));
      e.ovf  = (t > MAXS) || (t < MINS);
      e.cout = wide[W];
      e.sum  = (st && e.ovf) ? ((t > 0) ? W'(MAXS) : W'(MINS)) : wide[W-1:0];
      e.t    = 0;
      e.lat  = 1'b0;
      return e;
   endfunction

   function automatic logic [W-1:0] rnd_op();
      logic [W-1:0] v;
      case ($urandom_range(0, 7))
         0:       v = {1'b0, {(W-1){1'b1}}};
         1:       v = {1'b1, {(W-1){1'b0}}};
         2:       v = '1;
         3:       v = W'(32'h0000FFFF);
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Called on a falling edge. The operation is held until accepted, and its
   // expectation is queued at the accepting edge.
   task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic c, input logic s, input logic st, input exp_t e);
      int n;
      bit done;
      n = 0; done = 1'b0;
      in_valid = 1'b1; a = av; b = bv; cin = c; sub = s; sat = st;
      while (!done) begin
         #4;
         done = in_ready;
         if (done) begin
            e.t = cyc;
            q.push_back(e);
         end
         @(negedge clk);
         n++;
         if (!done && n > 1000) begin
            nvec++; nerr++;
            $display("FAIL send_timeout: in_ready still 0 after %0d cycles, expected 1", n);
            done = 1'b1;
         end
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Output monitor: pops one expectation per output transfer and checks that a stalled result holds steady.
   initial begin : mon
      exp_t         e;
      logic [W-1:0] psum;
      logic         pc, po;
      bit           hold;
      hold = 1'b0; psum = '0; pc = 1'b0; po = 1'b0;
      forever begin
         @(negedge clk);
         #4;
         if (rst) begin
            hold = 1'b0;
            continue;
         end
         if (hold) begin
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_sum",   64'(sum),       64'(psum));
            chk("hold_cout",  64'(cout),      64'(pc));
            chk("hold_ovf",   64'(overflow),  64'(po));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               nvec++; nerr++;
               $display("FAIL unexpected_output: got sum %0h with no op outstanding, expected none", sum);
            end else begin
               e = q.pop_front();
               chk("sum",  64'(sum),      64'(e.sum));
               chk("cout", 64'(cout),     64'(e.cout));
               chk("ovf",  64'(overflow), 64'(e.ovf));
               if (e.lat) chk("latency", 64'(cyc - e.t), 64'(ST));
            end
         end
         hold = out_valid && !out_ready;
         psum = sum; pc = cout; po = overflow;
      end
   end

   initial begin
      #600000;
      nerr++;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      int n;
      logic [W-1:0] ra, rb;
      logic rc, rs, rt;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; sat = 1'b0;
      ordy_fix = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #4;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_sum",       64'(sum),       64'(0));
      chk("rst_cout",      64'(cout),      64'(0));
      chk("rst_ovf",       64'(overflow),  64'(0));
      chk("rst_in_ready",  64'(in_ready),  64'(1));
      @(negedge clk);

      // Overflow with and without saturation, signed subtract, and a carry crossing the segment boundary.
      send(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0, mk(32'h80000000, 1'b0, 1'b1, 1'b1));
      send(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 1'b1, mk(32'h7FFFFFFF, 1'b0, 1'b1, 1'b1));
      send(32'h80000000, 32'h1, 1'b0, 1'b1, 1'b1, mk(32'h80000000, 1'b1, 1'b1, 1'b1));
      send(32'h5,        32'h7, 1'b0, 1'b1, 1'b0, mk(32'hFFFFFFFE, 1'b0, 1'b0, 1'b1));
      send(32'h0000FFFF, 32'h1, 1'b0, 1'b0, 1'b0, mk(32'h00010000, 1'b0, 1'b0, 1'b1));
      send(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0, mk(32'h00000000, 1'b1, 1'b0, 1'b1));
      send(32'hA,        32'h3, 1'b1, 1'b1, 1'b0, mk(32'h00000006, 1'b1, 1'b0, 1'b1));
      idle(ST + 3);

      // Four back-to-back ops while downstream stalls.
      ordy_fix = 1'b0;
      fork
         begin
            send(32'h1,        32'h2,   1'b0, 1'b0, 1'b0, mk(32'h3,        1'b0, 1'b0, 1'b0));
            send(32'h100,      32'h200, 1'b0, 1'b0, 1'b0, mk(32'h300,      1'b0, 1'b0, 1'b0));
            send(32'hFFFFFFFF, 32'h1,   1'b0, 1'b0, 1'b0, mk(32'h0,        1'b1, 1'b0, 1'b0));
            send(32'h3,        32'h5,   1'b0, 1'b1, 1'b0, mk(32'hFFFFFFFE, 1'b0, 1'b0, 1'b0));
         end
         begin
            repeat (6) @(negedge clk);
            #4;
            chk("stall_in_ready",  64'(in_ready),  64'(0));
            chk("stall_out_valid", 64'(out_valid), 64'(1));
            @(negedge clk);
            ordy_fix = 1'b1;
         end
      join
      idle(ST + 3);
      chk("stall_drained", 64'(q.size()), 64'(0));

      // Reset with two ops in flight: both are discarded.
      send(32'h11, 32'h22, 1'b0, 1'b0, 1'b0, mk(32'h33, 1'b0, 1'b0, 1'b0));
      send(32'h44, 32'h55, 1'b0, 1'b0, 1'b0, mk(32'h99, 1'b0, 1'b0, 1'b0));
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      q.delete();
      rst = 1'b0;
      #4;
      chk("flush_out_valid", 64'(out_valid), 64'(0));
      chk("flush_sum",       64'(sum),       64'(0));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #4;
         chk("flush_no_stale", 64'(out_valid), 64'(0));
      end
      @(negedge clk);

      // Random operands, random input gaps, and random downstream stalls.
      rnd_ordy = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         ra = rnd_op(); rb = rnd_op();
         rc = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         rt = 1'($urandom_range(0, 1));
         send(ra, rb, rc, rs, rt, model(ra, rb, rc, rs, rt));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      in_valid = 1'b0;
      rnd_ordy = 1'b0;
      ordy_fix = 1'b1;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      chk("final_drain", 64'(q.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
